// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg
//   Shared types and constants for the multi-channel fractional pulse
//   scheduler. Struct fields are sized for the largest legal configuration
//   (ACC_W up to 32, NCH up to 16). Narrower instances keep the unused upper
//   bits at zero, so carries and compares stay correct.
//
//   ch_state_t : per-channel accumulator (with carry bit), increment, enable
//   cfg_req_t  : one configuration request (channel, increment, enable)
//   CNT_W      : width of each optional per-channel pulse counter
package pulse_sched_pkg;

    localparam int ACC_W_MAX = 32;
    localparam int CH_W_MAX  = 4;
    localparam int CNT_W     = 8;

    typedef struct packed {
        logic [ACC_W_MAX:0]   acc;   // bit ACC_W of the active width is the carry
        logic [ACC_W_MAX-1:0] incr;
        logic                 en;
    } ch_state_t;

    typedef struct packed {
        logic [CH_W_MAX-1:0]  ch;
        logic [ACC_W_MAX-1:0] incr;
        logic                 en;
    } cfg_req_t;

endpackage

// File: rtl/pulse_sched_acc.sv
// pulse_sched_acc
//   Combinational shared accumulator adder. It is used once and is fed with
//   the state of whichever channel owns the current slot.
//
//   Ports:
//     cur     in  ch_state_t   state of the serviced channel
//     acc_nxt out ACC_W_MAX+1  next accumulator value (carry at bit ACC_W)
//     carry   out 1            carry out of the fraction; this is the tick
//
//   A disabled channel holds its accumulator and produces no carry.
module pulse_sched_acc
    import pulse_sched_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  ch_state_t            cur,
    output logic [ACC_W_MAX:0]   acc_nxt,
    output logic                 carry
);

    // Keeps only the fraction bits; the previous carry is dropped before adding.
    localparam logic [ACC_W_MAX:0] FRAC_MASK =
        (ACC_W_MAX+1)'((64'd1 << ACC_W) - 64'd1);

    logic [ACC_W_MAX:0] sum;

    always_comb begin
        sum = (cur.acc & FRAC_MASK) + {1'b0, cur.incr};
        if (cur.en) begin
            acc_nxt = sum;
            // Both operands are below 2^ACC_W, so only bit ACC_W can be set
            // above the fraction. OR-reducing the shifted sum yields that bit.
            carry   = |(sum >> ACC_W);
        end else begin
            acc_nxt = cur.acc;
            carry   = 1'b0;
        end
    end

endmodule

// File: rtl/pulse_sched.sv
// pulse_sched
//   Multi-channel fractional pulse scheduler. A slot counter (phase) services
//   one channel per cycle through a single shared adder. Channel c ticks at
//   f_clk / NCH * incr[c] / 2^ACC_W, and each tick is a registered 1-cycle
//   pulse.
//
//   Ports:
//     clk        in   1        system clock, rising edge
//     rst_n      in   1        synchronous active-low reset
//     cfg_valid  in   1        config request valid
//     cfg_ready  out  1        config request accepted when high with cfg_valid
//     cfg_ch     in   CH_W     target channel
//     cfg_incr   in   ACC_W    accumulator increment
//     cfg_en     in   1        channel enable
//     pulse      out  NCH      per-channel tick, at most one bit high per cycle
//     pulse_cnt  out  8*NCH    per-channel wrapping pulse counters
//                              (present only with PULSE_SCHED_CNT_EN)
//
//   Optional feature macro: PULSE_SCHED_CNT_EN (adds pulse_cnt).
//
//   Config handshake: a transfer happens on a rising edge where
//   cfg_valid && cfg_ready. cfg_ready is a register that equals !pend_v, and
//   the requester holds cfg_* stable while cfg_valid && !cfg_ready. An
//   accepted request waits in the single pending slot. It commits in the slot
//   of its channel, and that slot does no accumulate and emits no pulse.
//   A request to a channel >= NCH is dropped one cycle after acceptance.
module pulse_sched
    import pulse_sched_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int ACC_W = 16,
    parameter int CH_W  = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [ACC_W-1:0]   cfg_incr,
    input  logic               cfg_en,
    output logic [NCH-1:0]     pulse
`ifdef PULSE_SCHED_CNT_EN
    ,
    output logic [8*NCH-1:0]   pulse_cnt
`endif
);

    logic [CH_W-1:0]    phase;
    ch_state_t          st [NCH];
    cfg_req_t           pend;
    logic               pend_v;

    ch_state_t          cur;
    logic [ACC_W_MAX:0] acc_nxt;
    logic               carry;
    logic               commit;
    logic               drop;

    assign cur    = st[phase];
    assign commit = pend_v && (pend.ch == CH_W_MAX'(phase));
    // The compare is done at 32 bits so that NCH=16 does not wrap to zero.
    assign drop   = pend_v && (32'(pend.ch) >= 32'(NCH));

    pulse_sched_acc #(
        .ACC_W   (ACC_W)
    ) u_acc (
        .cur     (cur),
        .acc_nxt (acc_nxt),
        .carry   (carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase     <= '0;
            pulse     <= '0;
            pend_v    <= 1'b0;
            cfg_ready <= 1'b1;
            pend      <= '0;
            for (int c = 0; c < NCH; c++) begin
                st[c] <= '0;
            end
        end else begin
            phase <= (phase == CH_W'(NCH - 1)) ? '0 : phase + CH_W'(1);
            pulse <= '0;

            if (commit) begin
                st[phase].acc  <= '0;
                st[phase].incr <= pend.incr;
                st[phase].en   <= pend.en;
            end else begin
                st[phase].acc  <= acc_nxt;
                pulse[phase]   <= carry;
            end

            // cfg_ready always mirrors !pend_v, one register each.
            if (pend_v) begin
                if (commit || drop) begin
                    pend_v    <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            end else if (cfg_valid && cfg_ready) begin
                pend_v    <= 1'b1;
                cfg_ready <= 1'b0;
                pend.ch   <= CH_W_MAX'(cfg_ch);
                pend.incr <= ACC_W_MAX'(cfg_incr);
                pend.en   <= cfg_en;
            end
        end
    end

`ifdef PULSE_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt [NCH];

    // A counter and its pulse cannot collide with that channel's commit.
    // A pulse for c is high one cycle after c's slot, and by then phase has
    // moved on. Clear still takes priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (commit && (phase == CH_W'(c))) begin
                    cnt[c] <= '0;
                end else if (pulse[c]) begin
                    cnt[c] <= cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_cnt
        assign pulse_cnt[CNT_W*gi +: CNT_W] = cnt[gi];
    end
`endif

endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched
//   Bench for pulse_sched with NCH=4, ACC_W=4. A reference model written from
//   the rate and handshake rules predicts pulse, cfg_ready and, when the
//   feature is built in, pulse_cnt for every cycle. Directed scenarios then
//   check rates, latencies, reset and incr=0. A randomized config phase
//   follows.
module tb_pulse_sched;

  localparam int NCH   = 4;
  localparam int ACC_W = 4;
  localparam int CH_W  = 2;
  localparam int MOD   = 1 << ACC_W;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_incr;
  logic             cfg_en;
  logic [NCH-1:0]   pulse;
`ifdef PULSE_SCHED_CNT_EN
  logic [8*NCH-1:0] pulse_cnt;
`endif

  always #5 clk = ~clk;

  pulse_sched #(
    .NCH       (NCH),
    .ACC_W     (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_incr  (cfg_incr),
    .cfg_en    (cfg_en),
    .pulse     (pulse)
`ifdef PULSE_SCHED_CNT_EN
    ,
    .pulse_cnt (pulse_cnt)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int ch;
    int incr;
    bit en;
  } req_t;

  int             m_t;          // cycles since reset release; slot = m_t % NCH
  int             m_acc  [NCH];
  int             m_incr [NCH];
  bit             m_en   [NCH];
  int             m_cnt  [NCH];
  req_t           pend_q[$];
  logic [NCH-1:0] exp_pulse;
  logic           exp_ready;
  logic [NCH-1:0] exp_q[$];     // expected pulse vector, one entry per cycle

  // Predicts the state after the coming rising edge from the current inputs.
  function automatic void model_step();
    logic [NCH-1:0] np;
    int             c;
    bit             commit;
    req_t           r;
    np = '0;
    if (!rst_n) begin
      m_t = 0;
      for (int k = 0; k < NCH; k++) begin
        m_acc[k] = 0; m_incr[k] = 0; m_en[k] = 0; m_cnt[k] = 0;
      end
      pend_q.delete();
      exp_ready = 1'b1;
    end else begin
      c = m_t % NCH;
      commit = (pend_q.size() > 0) && (pend_q[0].ch == c);
      for (int k = 0; k < NCH; k++)
        if (exp_pulse[k]) m_cnt[k] = (m_cnt[k] + 1) % 256;
      if (commit) begin
        m_incr[c] = pend_q[0].incr;
        m_en[c]   = pend_q[0].en;
        m_acc[c]  = 0;
        m_cnt[c]  = 0;
      end else if (m_en[c]) begin
        m_acc[c] = m_acc[c] + m_incr[c];
        if (m_acc[c] >= MOD) begin
          np[c] = 1'b1;
          m_acc[c] = m_acc[c] - MOD;
        end
      end
      if (pend_q.size() > 0) begin
        if (commit || pend_q[0].ch >= NCH) void'(pend_q.pop_front());
      end else if (cfg_valid) begin
        r.ch = int'(cfg_ch); r.incr = int'(cfg_incr); r.en = cfg_en;
        pend_q.push_back(r);
      end
      exp_ready = (pend_q.size() == 0);
      m_t++;
    end
    exp_pulse = np;
    exp_q.push_back(np);
  endfunction

  // ---------------- per-cycle compare and statistics ----------------
  int cyc = 0;
  int pc       [NCH];
  int last_p   [NCH];
  int min_gap  [NCH];

  task automatic clear_stats();
    for (int k = 0; k < NCH; k++) begin
      pc[k] = 0; last_p[k] = -1; min_gap[k] = 1000000;
    end
  endtask

  task automatic tick();
    logic [NCH-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    check("pulse", 32'(pulse), 32'(e));
    check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
`ifdef PULSE_SCHED_CNT_EN
    for (int k = 0; k < NCH; k++)
      check("pulse_cnt", 32'(pulse_cnt[8*k +: 8]), 32'(m_cnt[k]));
`endif
    for (int k = 0; k < NCH; k++) begin
      if (pulse[k]) begin
        pc[k]++;
        if (last_p[k] >= 0 && (cyc - last_p[k]) < min_gap[k]) min_gap[k] = cyc - last_p[k];
        last_p[k] = cyc;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Raises cfg_valid and waits for the transfer edge. cfg_valid stays high
  // afterwards so that a following call presents a back-to-back request.
  task automatic send_cfg(input int ch, input int incr, input bit en);
    int w;
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_incr  = ACC_W'(incr);
    cfg_en    = en;
    w = 0;
    while (!cfg_ready && w < NCH + 4) begin
      tick();
      w++;
    end
    check("accept_in_time", 32'(cfg_ready), 32'd1);
    tick();
  endtask

  // Drops cfg_valid and waits until cfg_ready returns. The commit must fall
  // within NCH cycles of acceptance.
  task automatic wait_commit();
    int w;
    cfg_valid = 1'b0;
    w = 0;
    while (!cfg_ready && w < NCH) begin
      tick();
      w++;
    end
    check("commit_latency", 32'(cfg_ready), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called on the cycle after commit. With incr = MOD/2, the carry comes on
  // the second service after commit, so the pulse shows 2*NCH cycles later.
  task automatic first_pulse(input int ch, input string tag);
    int k;
    k = 0;
    while (!pulse[ch] && k < 4 * NCH) begin
      tick();
      k++;
    end
    check(tag, 32'(k), 32'(2 * NCH));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit xfer;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_incr  = '0;
    cfg_en    = 1'b0;
    clear_stats();
    tick();
    tick();
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // ch0 at half rate: one pulse every 2 services
    send_cfg(0, MOD / 2, 1'b1);
    wait_commit();
    first_pulse(0, "ch0_first_pulse");
    clear_stats();
    run(64);
    check("ch0_rate", 32'(pc[0]), 32'd8);

    // ch1 incr=5: 5 pulses per 16 services, spaced at least 8 cycles apart
    send_cfg(1, 5, 1'b1);
    wait_commit();
    clear_stats();
    run(64);
    check("ch1_rate", 32'(pc[1]), 32'd5);
    check("ch1_min_gap_ok", 32'(min_gap[1] >= 8), 32'd1);

    // back-to-back requests with cfg_valid held high
    send_cfg(2, 3, 1'b1);
    check("b2b_ready_low", 32'(cfg_ready), 32'd0);
    send_cfg(3, 7, 1'b1);
    wait_commit();
    clear_stats();
    run(64);
    check("ch2_rate", 32'(pc[2]), 32'd3);
    check("ch3_rate", 32'(pc[3]), 32'd7);

    // disable ch0, then re-enable and expect the accumulator restarted
    send_cfg(0, MOD / 2, 1'b0);
    wait_commit();
    clear_stats();
    run(64);
    check("ch0_disabled", 32'(pc[0]), 32'd0);
    send_cfg(0, MOD / 2, 1'b1);
    wait_commit();
    first_pulse(0, "ch0_reenable_first");

    // reset with channels running and a request pending
    send_cfg(2, 15, 1'b1);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_ready", 32'(cfg_ready), 32'd1);
    check("midrst_pulse", 32'(pulse), 32'd0);
    clear_stats();
    run(64);
    check("midrst_silent", 32'(pc[0] + pc[1] + pc[2] + pc[3]), 32'd0);

    // incr=0 never pulses
    send_cfg(2, 0, 1'b1);
    wait_commit();
    clear_stats();
    run(256);
    check("incr0_silent", 32'(pc[2]), 32'd0);

`ifdef PULSE_SCHED_CNT_EN
    // 256 pulses on ch0 bring its counter back to 0
    send_cfg(0, MOD / 2, 1'b1);
    wait_commit();
    run(2048);
    check("cnt_before_wrap", 32'(pulse_cnt[7:0]), 32'd255);
    tick();
    check("cnt_wrapped", 32'(pulse_cnt[7:0]), 32'd0);
`endif

    // randomized configuration traffic
    for (int i = 0; i < 400; i++) begin
      if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'($urandom_range(0, NCH - 1));
        cfg_incr  = ACC_W'($urandom_range(0, MOD - 1));
        cfg_en    = 1'($urandom_range(0, 1));
      end
      xfer = cfg_valid && cfg_ready;
      tick();
      if (xfer) cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;
    run(4 * NCH);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/pulse_sched.md
# pulse_sched

Multi-channel fractional pulse scheduler. It time-multiplexes one shared accumulator adder across `NCH` channels to produce per-channel 1-cycle tick pulses at runtime-programmable rates. Each channel's rate is `f_clk / NCH * incr / 2^ACC_W`. It sits between the control logic that writes rates and the consumers of tick strobes (baud, PWM and refresh timers), and replaces one fixed divider per consumer.

## Interface
Parameters:
- `NCH`, 4: number of channels, 2..16.
- `ACC_W`, 16: accumulator fraction width, 2..32.
- `CH_W`, `$clog2(NCH)`: channel index width (derived).

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_valid`  in  1  config request valid.
- `cfg_ready`  out  1  config request accepted when high with `cfg_valid`.
- `cfg_ch`  in  CH_W  target channel.
- `cfg_incr`  in  ACC_W  accumulator increment.
- `cfg_en`  in  1  channel enable.
- `pulse`  out  NCH  per-channel 1-cycle tick, registered.
- `pulse_cnt`  out  8*NCH  per-channel pulse counters (only with `PULSE_SCHED_CNT_EN`).

## Operation
- Slot counter `phase` cycles 0..NCH-1 and wraps to 0. Channel `phase` is serviced each cycle, so every channel is serviced once per NCH cycles.
- Per-channel state:
  - `acc[c]`, ACC_W+1 bits (bit ACC_W is the carry).
  - `incr[c]`, ACC_W bits.
  - `en[c]`, 1 bit.
- Service of an enabled channel c: `acc[c] <= {1'b0, acc[c][ACC_W-1:0]} + incr[c]`. The next-cycle `pulse[c]` equals the carry of that sum.
- Service of a disabled channel: acc is held and no pulse is produced.
- Arithmetic: unsigned. Carry out of the ACC_W+1 sum is impossible by construction. `incr=0` never pulses. Maximum rate is just under one pulse per service.
- Config handshake:
  - One pending slot (`pend_ch`, `pend_incr`, `pend_en`, `pend_v`).
  - `cfg_ready = !pend_v`, registered.
  - A transfer occurs when `cfg_valid && cfg_ready`; `pend_v` sets the next cycle.
- Commit: in the cycle where `pend_v && phase==pend_ch`:
  - `incr`/`en` are replaced.
  - `acc[pend_ch] <= 0`.
  - No accumulate and no pulse in that slot.
  - `pend_v` clears; `cfg_ready` is high the following cycle.
- `cfg_ch >= NCH`: accepted, `pend_v` set, then dropped without effect after one cycle (`pend_v` clears next cycle).
- Requesters must hold `cfg_*` stable while `cfg_valid && !cfg_ready`.

## Timing
- Reset (`rst_n` low at a clock edge):
  - `phase=0`; all acc, incr and en = 0.
  - `pulse=0`, `pend_v=0`, `cfg_ready=1`, `pulse_cnt=0`.
  - Applies mid-operation; a pending config is discarded.
- Pulse latency: serviced in cycle t means `pulse[c]` is high in cycle t+1 for exactly one cycle. At most one `pulse` bit is high in any cycle.
- Config latency: acceptance at cycle t gives commit in cycle t+1..t+NCH (first cycle ≥ t+1 with `phase==cfg_ch`). First possible new-rate pulse follows the channel's next service after commit.
- Accept and commit in the same cycle: impossible, because ready is low while pending.
- `phase` wrap has no special behaviour.

## Configuration
- `PULSE_SCHED_CNT_EN` defined:
  - Adds the `pulse_cnt` output. Counter c (bits 8c+7:8c) increments, wrapping at 8 bits, in the same cycle `pulse[c]` is high.
  - Counters clear on reset and on commit to channel c.
- Undefined: the port and counters are absent. All other behaviour is identical.

## Structure
- Package `pulse_sched_pkg`:
  - `ch_state_t` struct (acc, incr, en).
  - `cfg_req_t` struct (ch, incr, en).
  - `CNT_W=8` constant.
- Sub-module `pulse_sched_acc`: combinational shared adder. It takes acc, incr and en and returns the next acc and carry. It is instantiated once and fed by the `phase` mux.

## Test plan
- NCH=4, ACC_W=4. Write ch0 incr=8 en=1:
  - Commit within 4 cycles.
  - Then `pulse[0]` every 8 cycles, first pulse on the second ch0 service after commit.
- ch1 incr=5 en=1: exactly 5 `pulse[1]` per 64 cycles, never two within 8 cycles.
- Back-to-back config:
  - Second `cfg_valid` held high sees `cfg_ready` low until the cycle after the first commit.
  - Second config then accepted; both take effect.
- Disable ch0 (en=0) while running: no `pulse[0]` after commit. Re-enable with incr=8: first pulse 2 services later (acc restarted at 0).
- Assert `rst_n=0` for 1 cycle with ch0/ch1 active and a config pending:
  - All pulses stop.
  - `cfg_ready=1`.
  - Pending config never takes effect.
- `incr=0` en=1 on ch2: no pulses over 256 cycles. With `PULSE_SCHED_CNT_EN`: ch0 incr=8 for 2048 cycles gives `pulse_cnt[7:0]` wrapping to 0.
